// File: rtl/simplerisc_pkg.sv
// Shared types and constants for the simplerisc pipeline stages.
package simplerisc_pkg;

  typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_t;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch/squash event counters for fetch_unit; only built when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fetch,
  input  logic        i_squash,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_squash_count
);

  logic [31:0] r_fetch_count;
  logic [31:0] r_squash_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count  <= '0;
      r_squash_count <= '0;
    end else begin
      if (i_fetch)  r_fetch_count  <= r_fetch_count + 32'd1;
      if (i_squash) r_squash_count <= r_squash_count + 32'd1;
    end
  end

  assign o_fetch_count  = r_fetch_count;
  assign o_squash_count = r_squash_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/gnt/rvalid handshake, redirect squash.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/squash_count outputs.
module fetch_unit
  import simplerisc_pkg::*;
#(
  parameter int unsigned    AW       = 32,
  parameter logic [AW-1:0]  RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          isBranchTaken,
  input  logic [AW-1:0] branchPC,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  output logic [AW-1:0] if_pc,
  output logic [31:0]   if_inst,
  input  logic          if_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   squash_count
`endif
);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [AW-1:0] r_pc;
  logic          r_if_valid;
  logic [AW-1:0] r_if_pc;
  logic [31:0]   r_if_inst;

  logic          w_req;
  logic          w_grant;
  logic          w_load;
  logic          w_squash;
  logic [AW-1:0] w_branch_pc;

  assign w_branch_pc = {branchPC[AW-1:2], 2'b00};
  assign w_grant     = w_req && imem_gnt;
  assign w_load      = (r_state == WAIT) && imem_rvalid && !isBranchTaken;
  assign w_squash    = isBranchTaken &&
                       (r_if_valid || (r_state == WAIT) || ((r_state == REQ) && w_req));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= REQ;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      REQ:   if (w_grant) w_state_nxt = isBranchTaken ? DRAIN : WAIT;
      WAIT:  if (imem_rvalid)        w_state_nxt = REQ;
             else if (isBranchTaken) w_state_nxt = DRAIN;
      DRAIN: if (imem_rvalid) w_state_nxt = REQ;
      default: w_state_nxt = REQ;
    endcase
  end

  // Request only when the output slot can absorb the response; gated by rst_n so it is low in reset.
  always_comb begin
    w_req     = rst_n && (r_state == REQ) && (!r_if_valid || if_ready);
    imem_req  = w_req;
    imem_addr = r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
    end else if (isBranchTaken) begin
      r_pc       <= w_branch_pc;
      r_if_valid <= 1'b0;
    end else if (w_load) begin
      r_pc       <= r_pc + AW'(INST_BYTES);
      r_if_valid <= 1'b1;
      r_if_pc    <= r_pc;
      r_if_inst  <= imem_rdata;
    end else if (if_ready) begin
      r_if_valid <= 1'b0;
    end
  end

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fetch        (w_load),
    .i_squash       (w_squash),
    .o_fetch_count  (fetch_count),
    .o_squash_count (squash_count)
  );
`else
  logic w_unused_squash;
  assign w_unused_squash = w_squash;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus a RESET_PC wrap instance.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ibt;
  logic [31:0] bpc;
  logic        gnt, rv, rdy;
  logic [31:0] rdata;

  logic        req, valid;
  logic [31:0] addr, ipc, inst;
  logic        req2, valid2;
  logic [31:0] addr2, ipc2, inst2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, scnt, fcnt2, scnt2;
`endif

  fetch_unit #(.AW(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .isBranchTaken(ibt), .branchPC(bpc),
    .imem_req(req), .imem_addr(addr), .imem_gnt(gnt), .imem_rvalid(rv),
    .imem_rdata(rdata), .if_valid(valid), .if_pc(ipc), .if_inst(inst),
    .if_ready(rdy)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fcnt), .squash_count(scnt)
`endif
  );

  fetch_unit #(.AW(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .isBranchTaken(1'b0), .branchPC(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt), .imem_rvalid(rv),
    .imem_rdata(rdata), .if_valid(valid2), .if_pc(ipc2), .if_inst(inst2),
    .if_ready(rdy)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fcnt2), .squash_count(scnt2)
`endif
  );

  typedef struct {
    logic        ibt;
    logic [31:0] bpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic i_b, input logic [31:0] b_pc, input logic g, input logic r,
                     input logic [31:0] d, input logic rd, input logic e_rq,
                     input logic [31:0] e_a, input logic e_vl, input logic [31:0] e_p,
                     input logic [31:0] e_i);
    vec_t v;
    v.ibt = i_b; v.bpc = b_pc; v.gnt = g; v.rv = r; v.rdata = d; v.rdy = rd;
    v.e_req = e_rq; v.e_addr = e_a; v.e_v = e_vl; v.e_pc = e_p; v.e_inst = e_i;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; ibt = 1'b0; bpc = '0; gnt = 1'b0; rv = 1'b0; rdata = '0; rdy = 1'b1;

    //   ibt bpc          gnt rv rdata         rdy | req addr          v pc            inst
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_0000, 0, 32'h0,   32'h0);
    add(0, 32'h0,       0, 1, 32'hA000_0000,1,   0, 32'h0000_0000, 0, 32'h0,   32'h0);
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_0004, 1, 32'h0,   32'hA000_0000);
    add(0, 32'h0,       0, 1, 32'hA000_0004,1,   0, 32'h0000_0004, 0, 32'h0,   32'hA000_0000);
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_0008, 1, 32'h4,   32'hA000_0004);
    add(0, 32'h0,       0, 1, 32'hA000_0008,1,   0, 32'h0000_0008, 0, 32'h4,   32'hA000_0004);
    for (int i = 0; i < 5; i++)
      add(0, 32'h0,     1, 0, 32'h0,        0,   0, 32'h0000_000C, 1, 32'h8,   32'hA000_0008);
    add(0, 32'h0,       0, 0, 32'h0,        1,   1, 32'h0000_000C, 1, 32'h8,   32'hA000_0008);
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_000C, 0, 32'h8,   32'hA000_0008);
    add(0, 32'h0,       0, 0, 32'h0,        1,   0, 32'h0000_000C, 0, 32'h8,   32'hA000_0008);
    add(0, 32'h0,       0, 1, 32'hA000_000C,1,   0, 32'h0000_000C, 0, 32'h8,   32'hA000_0008);
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_0010, 1, 32'hC,   32'hA000_000C);
    add(1, 32'h0000_0103,0,0, 32'h0,        1,   0, 32'h0000_0010, 0, 32'hC,   32'hA000_000C);
    add(0, 32'h0,       0, 1, 32'hA000_0010,1,   0, 32'h0000_0100, 0, 32'hC,   32'hA000_000C);
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_0100, 0, 32'hC,   32'hA000_000C);
    add(0, 32'h0,       0, 1, 32'hA000_0100,1,   0, 32'h0000_0100, 0, 32'hC,   32'hA000_000C);
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_0104, 1, 32'h100, 32'hA000_0100);
    add(1, 32'h0000_0200,0,1, 32'hA000_0104,1,   0, 32'h0000_0104, 0, 32'h100, 32'hA000_0100);
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_0200, 0, 32'h100, 32'hA000_0100);
    add(0, 32'h0,       0, 1, 32'hA000_0200,1,   0, 32'h0000_0200, 0, 32'h100, 32'hA000_0100);
    add(1, 32'h0000_0302,1,0, 32'h0,        1,   1, 32'h0000_0204, 1, 32'h200, 32'hA000_0200);
    add(1, 32'h0000_0310,0,0, 32'h0,        1,   0, 32'h0000_0300, 0, 32'h200, 32'hA000_0200);
    add(0, 32'h0,       0, 1, 32'hA000_0204,1,   0, 32'h0000_0310, 0, 32'h200, 32'hA000_0200);
    add(1, 32'h0000_0404,0,0, 32'h0,        1,   1, 32'h0000_0310, 0, 32'h200, 32'hA000_0200);
    add(0, 32'h0,       1, 0, 32'h0,        1,   1, 32'h0000_0404, 0, 32'h200, 32'hA000_0200);
    add(0, 32'h0,       0, 1, 32'hA000_0404,1,   0, 32'h0000_0404, 0, 32'h200, 32'hA000_0200);
    add(0, 32'h0,       0, 0, 32'h0,        1,   1, 32'h0000_0408, 1, 32'h404, 32'hA000_0404);
    add(0, 32'h0,       0, 0, 32'h0,        1,   1, 32'h0000_0408, 0, 32'h404, 32'hA000_0404);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_req",   {31'h0, req},   32'h0);
    chk("reset_addr",  addr,           32'h0);
    chk("reset_pc",    ipc,            32'h0);
    chk("reset_inst",  inst,           32'h0);
    chk("reset_addr_wrap", addr2,      32'hFFFF_FFFC);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      ibt = vecs[i].ibt; bpc = vecs[i].bpc; gnt = vecs[i].gnt;
      rv  = vecs[i].rv;  rdata = vecs[i].rdata; rdy = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_req",  i), {31'h0, req},   {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), addr,           vecs[i].e_addr);
      chk($sformatf("v%0d_valid",i), {31'h0, valid}, {31'h0, vecs[i].e_v});
      chk($sformatf("v%0d_pc",   i), ipc,            vecs[i].e_pc);
      chk($sformatf("v%0d_inst", i), inst,           vecs[i].e_inst);
      if (i < 6) chk($sformatf("wrap_v%0d_addr", i), addr2, vecs[i].e_addr - 32'd4);
      if (i == 2) chk("wrap_if_pc", ipc2, 32'hFFFF_FFFC);
      @(negedge clk);
    end

`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count",  fcnt, 32'd7);
    chk("squash_count", scnt, 32'd4);
`endif

    // Reset while a response is outstanding; the late response must be ignored.
    ibt = 1'b0; gnt = 1'b1; rv = 1'b0; rdy = 1'b1;
    #1;
    chk("pre_rst_addr", addr, 32'h0000_0408);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_addr",  addr,           32'h0);
    chk("async_rst_req",   {31'h0, req},   32'h0);
    chk("async_rst_pc",    ipc,            32'h0);
    @(negedge clk);
    rst_n = 1'b1; gnt = 1'b0; rv = 1'b1; rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("late_rsp_valid", {31'h0, valid}, 32'h0);
    chk("late_rsp_inst",  inst,           32'h0);
    @(negedge clk);
    rv = 1'b0; gnt = 1'b1;
    #1;
    chk("post_rst_req",  {31'h0, req}, 32'h1);
    chk("post_rst_addr", addr,         32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("post_rst_fcnt", fcnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
